// File: rtl/v30mz_pkg.sv
// Shared v30mz definitions used by the bus arbiter.
// Holds the EU bus command codes, the external bus status codes, the arbiter
// state enum, and the helpers that map a request onto the bus lanes.
package v30mz_pkg;

  typedef logic [19:0] addr_t;

  localparam logic [2:0] BUS_COMMAND_IDLE      = 3'd0;
  localparam logic [2:0] BUS_COMMAND_MEM_READ  = 3'd1;
  localparam logic [2:0] BUS_COMMAND_MEM_WRITE = 3'd2;
  localparam logic [2:0] BUS_COMMAND_IO_READ   = 3'd3;
  localparam logic [2:0] BUS_COMMAND_IO_WRITE  = 3'd4;

  localparam logic [3:0] BUS_STATUS_IDLE      = 4'hf;
  localparam logic [3:0] BUS_STATUS_MEM_READ  = 4'b1001;
  localparam logic [3:0] BUS_STATUS_MEM_WRITE = 4'b1010;
  localparam logic [3:0] BUS_STATUS_IO_READ   = 4'b0101;
  localparam logic [3:0] BUS_STATUS_IO_WRITE  = 4'b0110;
  localparam logic [3:0] BUS_STATUS_FETCH     = 4'b1001;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CYC1 = 2'd1,
    ARB_CYC2 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        upper;
    logic [15:0] data;
  } lane_t;

  // Unknown non-idle commands still get a bus cycle so the requester
  // is never left waiting; they run as a memory read.
  function automatic logic [3:0] cmd_status(input logic [2:0] cmd);
    case (cmd)
      BUS_COMMAND_MEM_WRITE: return BUS_STATUS_MEM_WRITE;
      BUS_COMMAND_IO_READ:   return BUS_STATUS_IO_READ;
      BUS_COMMAND_IO_WRITE:  return BUS_STATUS_IO_WRITE;
      default:               return BUS_STATUS_MEM_READ;
    endcase
  endfunction

  // Lane enable and write data for one bus cycle. Byte cycles drive the
  // selected byte on both lanes so the target can pick either one.
  // The first half of a split word is an odd-byte cycle with the low byte;
  // the second half is an even-byte cycle with the high byte.
  function automatic lane_t lane_steer(input logic        word,
                                       input logic        a0,
                                       input logic        second,
                                       input logic [15:0] wdata);
    lane_t l;
    if (second) begin
      l.upper = 1'b0;
      l.data  = {2{wdata[15:8]}};
    end else if (word && !a0) begin
      l.upper = 1'b1;
      l.data  = wdata;
    end else begin
      l.upper = a0;
      l.data  = {2{wdata[7:0]}};
    end
    return l;
  endfunction

  // Read data for a non-split cycle.
  function automatic logic [15:0] read_steer(input logic        word,
                                             input logic        a0,
                                             input logic [15:0] din);
    if (word)    return din;
    else if (a0) return {8'h00, din[15:8]};
    else         return {8'h00, din[7:0]};
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and external-bus signal bundle for bus_arbiter.
// master: the arbiter (owns the bus, returns done/data to requesters).
// slave : the environment (EU, prefetch queue, bus target).
interface bus_arbiter_if;
  import v30mz_pkg::*;

  // Execution unit
  logic [2:0]  eu_cmd;
  addr_t       eu_addr;
  logic        eu_word;
  logic [15:0] eu_wdata;
  logic        eu_done;
  logic [15:0] eu_rdata;
  // Prefetch queue
  logic        pf_req;
  addr_t       pf_addr;
  logic        pf_cancel;
  logic        pf_done;
  logic [15:0] pf_data;
  logic        pf_byte;
  // External bus
  logic        readyb;
  logic [15:0] data_in;
  addr_t       address_out;
  logic [15:0] data_out;
  logic [3:0]  bus_status;
  logic        bus_upper_byte_enable;
  logic        busy;

  modport master (
    input  eu_cmd, eu_addr, eu_word, eu_wdata,
    output eu_done, eu_rdata,
    input  pf_req, pf_addr, pf_cancel,
    output pf_done, pf_data, pf_byte,
    input  readyb, data_in,
    output address_out, data_out, bus_status, bus_upper_byte_enable, busy
  );

  modport slave (
    output eu_cmd, eu_addr, eu_word, eu_wdata,
    input  eu_done, eu_rdata,
    output pf_req, pf_addr, pf_cancel,
    input  pf_done, pf_data, pf_byte,
    output readyb, data_in,
    input  address_out, data_out, bus_status, bus_upper_byte_enable, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// v30mz bus control unit.
// Arbitrates the external bus between EU data/IO accesses (priority) and
// prefetch fetches, runs each cycle until readyb is sampled low, and splits
// odd-address word accesses into two byte cycles.
// Ports: clk, reset (sync, active-high), bif (bus_arbiter_if.master).
module bus_arbiter
  import v30mz_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  bus_arbiter_if.master  bif
);

  arb_state_e  state_q, state_d;
  addr_t       addr_q, addr_d;
  logic [3:0]  status_q, status_d;
  logic        upper_q, upper_d;
  logic [15:0] dout_q, dout_d;
  logic [7:0]  whi_q, whi_d;     // write high byte, needed by the second split half
  logic [7:0]  lo_q, lo_d;       // read low byte captured by the first split half
  logic        pf_own_q, pf_own_d;
  logic        word_q, word_d;
  logic        a0_q, a0_d;
  logic        split_q, split_d;
  logic        cancel_q, cancel_d;

  logic        rdy;
  logic        eu_done_c, pf_done_c;
  logic [15:0] rdata_c;
  lane_t       lane1, lane2;

  assign rdy   = !bif.readyb;
  assign lane1 = lane_steer(bif.eu_word, bif.eu_addr[0], 1'b0, bif.eu_wdata);
  assign lane2 = lane_steer(1'b1, 1'b1, 1'b1, {whi_q, 8'h00});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    status_d  = status_q;
    upper_d   = upper_q;
    dout_d    = dout_q;
    whi_d     = whi_q;
    lo_d      = lo_q;
    pf_own_d  = pf_own_q;
    word_d    = word_q;
    a0_d      = a0_q;
    split_d   = split_q;
    cancel_d  = cancel_q;
    eu_done_c = 1'b0;
    pf_done_c = 1'b0;
    rdata_c   = 16'h0000;

    case (state_q)
      ARB_IDLE: begin
        if (bif.eu_cmd != BUS_COMMAND_IDLE) begin
          addr_d   = bif.eu_addr;
          status_d = cmd_status(bif.eu_cmd);
          upper_d  = lane1.upper;
          dout_d   = lane1.data;
          whi_d    = bif.eu_wdata[15:8];
          pf_own_d = 1'b0;
          word_d   = bif.eu_word;
          a0_d     = bif.eu_addr[0];
          split_d  = bif.eu_word & bif.eu_addr[0];
          cancel_d = 1'b0;
          state_d  = ARB_CYC1;
        end else if (bif.pf_req && !bif.pf_cancel) begin
          addr_d   = bif.pf_addr;
          status_d = BUS_STATUS_FETCH;
          upper_d  = 1'b1;
          pf_own_d = 1'b1;
          word_d   = 1'b1;
          a0_d     = bif.pf_addr[0];
          split_d  = 1'b0;
          cancel_d = 1'b0;
          state_d  = ARB_CYC1;
        end
      end

      ARB_CYC1: begin
        // Remember a flush seen during any wait state of a prefetch.
        if (pf_own_q && bif.pf_cancel) cancel_d = 1'b1;
        if (rdy) begin
          if (split_q) begin
            lo_d    = bif.data_in[15:8];
            addr_d  = addr_q + 20'd1;
            upper_d = lane2.upper;
            dout_d  = lane2.data;
            state_d = ARB_CYC2;
          end else begin
            if (pf_own_q) pf_done_c = !(cancel_q || bif.pf_cancel);
            else          eu_done_c = 1'b1;
            rdata_c  = read_steer(word_q, a0_q, bif.data_in);
            status_d = BUS_STATUS_IDLE;
            state_d  = ARB_IDLE;
          end
        end
      end

      ARB_CYC2: begin
        if (rdy) begin
          eu_done_c = 1'b1;
          rdata_c   = {bif.data_in[7:0], lo_q};
          status_d  = BUS_STATUS_IDLE;
          state_d   = ARB_IDLE;
        end
      end

      default: begin
        status_d = BUS_STATUS_IDLE;
        state_d  = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      addr_q   <= 20'hfffff;
      status_q <= BUS_STATUS_IDLE;
      upper_q  <= 1'b0;
      dout_q   <= 16'h0000;
      whi_q    <= 8'h00;
      lo_q     <= 8'h00;
      pf_own_q <= 1'b0;
      word_q   <= 1'b0;
      a0_q     <= 1'b0;
      split_q  <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      status_q <= status_d;
      upper_q  <= upper_d;
      dout_q   <= dout_d;
      whi_q    <= whi_d;
      lo_q     <= lo_d;
      pf_own_q <= pf_own_d;
      word_q   <= word_d;
      a0_q     <= a0_d;
      split_q  <= split_d;
      cancel_q <= cancel_d;
    end
  end

  // Done pulses are combinational; reset in the same cycle aborts the
  // access without completing it.
  assign bif.eu_done  = eu_done_c & !reset;
  assign bif.pf_done  = pf_done_c & !reset;
  assign bif.eu_rdata = bif.eu_done ? rdata_c : 16'h0000;
  assign bif.pf_data  = bif.pf_done ? bif.data_in : 16'h0000;
  assign bif.pf_byte  = bif.pf_done & a0_q;

  assign bif.address_out           = addr_q;
  assign bif.data_out              = dout_q;
  assign bif.bus_status            = status_q;
  assign bif.bus_upper_byte_enable = upper_q;
  assign bif.busy                  = (state_q != ARB_IDLE);

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Bus control unit for the v30mz core. It owns the external bus and arbitrates between two requesters: execution-unit data/IO accesses and prefetch-queue instruction fetches. It runs each bus cycle through the `readyb` wait handshake. Word accesses at odd addresses are split into two byte cycles, and assembled data is returned to the requester.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk

Execution-unit requester:
- eu_cmd  in  3  bus command; non-IDLE requests a cycle; held stable until eu_done
- eu_addr  in  20  physical byte address
- eu_word  in  1  1 = 16-bit access, 0 = byte access
- eu_wdata  in  16  write data; byte uses [7:0]
- eu_done  out  1  one-cycle completion pulse
- eu_rdata  out  16  read result, valid with eu_done

Prefetch requester:
- pf_req  in  1  prefetch request
- pf_addr  in  20  fetch address
- pf_cancel  in  1  queue flush; suppresses the pending pf_done
- pf_done  out  1  one-cycle completion pulse
- pf_data  out  16  data_in as sampled
- pf_byte  out  1  odd fetch; only pf_data[15:8] is valid

External bus:
- readyb  in  1  active-low ready; ends the current bus cycle
- data_in  in  16  bus read data
- address_out  out  20  bus address
- data_out  out  16  bus write data
- bus_status  out  4  cycle type
- bus_upper_byte_enable  out  1  upper lane active
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CYC1, CYC2.
- **IDLE**
  - Grant goes to EU if eu_cmd != IDLE. Otherwise it goes to the prefetch if pf_req && !pf_cancel.
  - The grant registers address, status, lane and write data, then moves to CYC1.
  - No request: bus_status = 4'hf.
- **CYC1**
  - Outputs are held. Wait while readyb = 1.
  - On readyb = 0 with a non-split access: pulse done and go to IDLE.
  - On readyb = 0 with a split access: latch data_in[15:8] as the low byte, register address+1 (20-bit wrap, 20'hfffff → 20'h00000) with the lower lane, and go to CYC2.
- **CYC2**
  - On readyb = 0: eu_rdata = {data_in[7:0], latched}, pulse eu_done, go to IDLE.
  - A split is atomic: no prefetch is granted between the halves.
- **Status codes**
  - Memory read and prefetch: 4'b1001.
  - Memory write: 4'b1010.
  - IO read: 4'b0101.
  - IO write: 4'b0110.
- **Lanes** (A = address bit 0)
  - Even word: upper = 1.
  - Even byte: upper = 0.
  - Odd byte: upper = 1.
  - Prefetch: upper = 1. An odd prefetch sets pf_byte.
- **Read data**
  - Even word: data_in.
  - Even byte: {8'h00, data_in[7:0]}.
  - Odd byte: {8'h00, data_in[15:8]}.
- **Write data**
  - Word: eu_wdata.
  - Byte, or either split half: the selected byte duplicated onto both lanes. The first split half uses [7:0]; the second uses [15:8].
- **pf_cancel**
  - If asserted during an in-flight prefetch, including the readyb-low cycle, the bus cycle still completes but pf_done is not pulsed.
- **EU priority**
  - An in-flight prefetch is never preempted; EU waits.

## Timing
- **Reset values**
  - address_out = 20'hfffff, bus_status = 4'hf.
  - data_out = 0, bus_upper_byte_enable = 0.
  - eu_done = pf_done = 0, eu_rdata = pf_data = 0, pf_byte = 0.
  - State = IDLE, busy = 0.
- **Reset mid-cycle**
  - Immediate return to IDLE with no done pulse. Requesters reissue.
- **Latency**
  - A request sampled in IDLE drives the bus the next cycle.
  - Done is combinational in the cycle readyb is sampled low.
  - Minimum 2 cycles per access, 3 per split access, plus wait states.
- **Back-to-back**
  - At least one IDLE cycle (status 4'hf) between transactions.
- Requesters must hold their inputs until done; the bus side samples them only at grant.

## Structure
- **Shared package (v30mz_pkg)**
  - BUS_COMMAND_* constants (IDLE = 0, MEM_READ = 1, MEM_WRITE = 2, IO_READ = 3, IO_WRITE = 4).
  - Bus status code constants.
  - Arbiter state enum.
- No sub-module. Lane steering is a package function.

## Test plan
- **Reset:** hold reset 3 cycles → address_out 20'hfffff, bus_status 4'hf, busy 0, no done pulses.
- **Even prefetch:** pf_req, pf_addr 20'h00100, readyb low after 2 waits, data_in 16'hBEEF → bus_status 4'b1001, upper 1, pf_done with pf_data 16'hBEEF, pf_byte 0, then one IDLE cycle.
- **Odd EU word read:** eu_cmd MEM_READ, eu_word 1, eu_addr 20'h12345; data_in 16'hAA00 then 16'h00BB, immediate ready → addresses 12345 (upper 1) then 12346 (upper 0), single eu_done, eu_rdata 16'hBBAA.
- **Simultaneous requests:** EU byte write to 20'h00010 with data 16'h0077, plus pf_req → EU first, status 4'b1010, data_out 16'h7777, upper 0; prefetch granted after one IDLE cycle.
- **Cancel:** pf_cancel pulsed during prefetch wait states → cycle ends on readyb low, no pf_done, returns to IDLE.
- **Wrap:** EU word read at 20'hfffff → second half at address 20'h00000, eu_done only after CYC2.
